// File: rtl/integral_tile_writer.sv
`default_nettype none
// ============================================================================
// Module   : integral_tile_writer
// Function : Streams one square tile of raster pixels and writes its
//            summed-area (integral) image into a core image memory, one
//            word per accepted pixel (plus zero pad words when enabled).
// Options  : INTEGRAL_PAD_EN - emit a (W+1)x(W+1) image with a zero top row
//            and zero left column (stride W+1); otherwise W x W, stride W.
// Revision : 1.0 - initial release
// ============================================================================
module integral_tile_writer #(
    parameter int MAX_W  = 320,
    parameter int PIX_W  = 8,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [31:0]       width_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic [PIX_W-1:0]  pix_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [OUT_W-1:0]  wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // Counter width holds values up to MAX_W+1 (the padded stride).
    localparam int CW = $clog2(MAX_W + 2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd3;
`ifdef INTEGRAL_PAD_EN
    localparam logic [1:0] ST_PAD_ROW = 2'd1;
    localparam logic [1:0] ST_PAD_COL = 2'd2;
`endif

    logic [1:0]        state_q,   state_d;
    logic [CW-1:0]     w_q,       w_d;
    logic [CW-1:0]     stride_q,  stride_d;
    logic [CW-1:0]     x_q,       x_d;
    logic [CW-1:0]     y_q,       y_d;
    logic [OUT_W-1:0]  row_sum_q, row_sum_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    // Previous row's integral values, indexed by column. Row 0 never reads it,
    // so stale contents from an earlier or aborted tile are harmless.
    logic [OUT_W-1:0]  line_buf_q [0:MAX_W-1];

    logic              w_accept;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_last_col;
    logic              w_last_row;
    logic [OUT_W-1:0]  w_sum;
    logic [OUT_W-1:0]  w_above;
    logic [OUT_W-1:0]  w_integral;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_stride_ext;
    logic [ADDR_W-1:0] w_run_addr;
`ifdef INTEGRAL_PAD_EN
    logic [ADDR_W-1:0] w_col_addr;
`endif

    assign pix_ready_o = (state_q == ST_RUN);
    assign w_accept    = pix_valid_i && pix_ready_o;

    assign w_start_ok  = start_i && (state_q == ST_IDLE) &&
                         (width_i >= 32'd2) && (width_i <= 32'(MAX_W));
    assign w_start_bad = start_i && (state_q == ST_IDLE) && !w_start_ok;

    assign w_last_col  = (x_q == w_q - 1'b1);
    assign w_last_row  = (y_q == w_q - 1'b1);

    assign w_sum       = row_sum_q + OUT_W'(pix_data_i);
    assign w_above     = (y_q == '0) ? '0 : line_buf_q[x_q];
    assign w_integral  = w_sum + w_above;

    assign w_x_ext      = ADDR_W'(x_q);
    assign w_y_ext      = ADDR_W'(y_q);
    assign w_stride_ext = ADDR_W'(stride_q);

`ifdef INTEGRAL_PAD_EN
    // Padded image: data row y lives in memory row y+1, column x in x+1.
    assign w_col_addr = (w_y_ext + ADDR_W'(1)) * w_stride_ext;
    assign w_run_addr = w_col_addr + w_x_ext + ADDR_W'(1);
`else
    assign w_run_addr = w_y_ext * w_stride_ext + w_x_ext;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        stride_d  = stride_q;
        x_d       = x_q;
        y_d       = y_q;
        row_sum_d = row_sum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;

        // busy drops the cycle after done unless a new tile starts right then.
        if (w_start_ok) begin
            busy_d = 1'b1;
        end else if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_d       = width_i[CW-1:0];
                    x_d       = '0;
                    y_d       = '0;
                    row_sum_d = '0;
`ifdef INTEGRAL_PAD_EN
                    stride_d  = width_i[CW-1:0] + 1'b1;
                    state_d   = ST_PAD_ROW;
`else
                    stride_d  = width_i[CW-1:0];
                    state_d   = ST_RUN;
`endif
                end else if (w_start_bad) begin
                    err_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (w_accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = w_run_addr;
                    wr_data_d = w_integral;
                    row_sum_d = w_sum;
                    if (w_last_col) begin
                        x_d       = '0;
                        y_d       = y_q + 1'b1;
                        row_sum_d = '0;
                        if (w_last_row) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
`ifdef INTEGRAL_PAD_EN
                            state_d = ST_PAD_COL;
`endif
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end

`ifdef INTEGRAL_PAD_EN
            // x doubles as the column counter for the zero top row.
            ST_PAD_ROW: begin
                wr_en_d   = 1'b1;
                wr_addr_d = w_x_ext;
                wr_data_d = '0;
                if (x_q == w_q) begin
                    x_d     = '0;
                    state_d = ST_PAD_COL;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            ST_PAD_COL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = w_col_addr;
                wr_data_d = '0;
                state_d   = ST_RUN;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts a tile with no further writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            w_q       <= '0;
            stride_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            row_sum_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            stride_q  <= stride_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_sum_q <= row_sum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Line buffer update: the new integral becomes the "above" value next row.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            line_buf_q[x_q] <= w_integral;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire
